// File: rtl/digital_pll_pkg.sv
// Shared sizing helpers and default constants for the digital FLL/PLL controllers.
package digital_pll_pkg;

   localparam int DEF_TRIM_W   = 26;
   localparam int DEF_DIV_W    = 5;
   localparam int DEF_TOL      = 1;
   localparam int DEF_LOCK_CNT = 4;

   function automatic int cnt_w(input int div_w);
      return div_w + 1;
   endfunction

   function automatic int code_w(input int trim_w);
      return $clog2(trim_w + 1);
   endfunction

endpackage

// File: rtl/pll_edge_sync.sv
// Two-flop synchroniser for the reference oscillator plus an edge register; pulses rise once per osc rising edge.
module pll_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic osc,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= osc;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/digital_fll_controller_p.sv
// Frequency-locked loop controller: counts DCO cycles per osc period and steps a thermometer trim
// one code per measurement until the count stays inside div +/- TOL.
module digital_fll_controller_p
   import digital_pll_pkg::*;
#(
   parameter int DIV_W     = DEF_DIV_W,
   parameter int TRIM_W    = DEF_TRIM_W,
   parameter int TOL       = DEF_TOL,
   parameter int LOCK_CNT  = DEF_LOCK_CNT,
   parameter int INIT_CODE = 13
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        osc,
   input  logic [DIV_W-1:0]            div,
   input  logic                        dco,
   input  logic [TRIM_W-1:0]           ext_trim,
   output logic [TRIM_W-1:0]           trim,
   output logic [code_w(TRIM_W)-1:0]   code,
   output logic [cnt_w(DIV_W)-1:0]     meas_count,
   output logic                        meas_valid,
   output logic                        locked
);

   localparam int CNT_W  = cnt_w(DIV_W);
   localparam int CODE_W = code_w(TRIM_W);
   localparam int CMP_W  = CNT_W + 2;
   localparam int RUN_W  = 4;

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CODE_W-1:0] CODE_TOP = CODE_W'(TRIM_W);
   localparam logic [CODE_W-1:0] CODE_RST = CODE_W'(INIT_CODE);
   localparam logic [RUN_W:0]    LOCK_N   = (RUN_W+1)'(LOCK_CNT);

   logic                    rise;
   logic [CNT_W-1:0]        cnt;
   logic                    first;
   logic [RUN_W-1:0]        run;
   logic [TRIM_W-1:0]       trim_q;

   logic signed [CMP_W-1:0] cnt_x;
   logic signed [CMP_W-1:0] hi_x;
   logic signed [CMP_W-1:0] lo_x;
   logic                    too_fast;
   logic                    too_slow;
   logic [RUN_W:0]          run_inc;
   logic [RUN_W-1:0]        run_nxt;

   function automatic logic [TRIM_W-1:0] therm(input logic [CODE_W-1:0] c);
      logic [TRIM_W-1:0] t;
      for (int i = 0; i < TRIM_W; i++) begin
         t[i] = (i < int'(c));
      end
      return t;
   endfunction

   pll_edge_sync u_edge_sync (
      .clock (clock),
      .reset (reset),
      .osc   (osc),
      .rise  (rise)
   );

   // Two guard bits keep div-TOL negative instead of wrapping when div < TOL.
   always_comb begin
      cnt_x    = $signed({2'b00, cnt});
      hi_x     = $signed({{(CMP_W-DIV_W){1'b0}}, div}) + $signed(CMP_W'(TOL));
      lo_x     = $signed({{(CMP_W-DIV_W){1'b0}}, div}) - $signed(CMP_W'(TOL));
      too_fast = (cnt_x > hi_x);
      too_slow = (cnt_x < lo_x);
      run_inc  = {1'b0, run} + (RUN_W+1)'(1);
      run_nxt  = (run_inc >= LOCK_N) ? LOCK_N[RUN_W-1:0] : run_inc[RUN_W-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt        <= '0;
         first      <= 1'b1;
         code       <= CODE_RST;
         run        <= '0;
         locked     <= 1'b0;
         meas_count <= '0;
         meas_valid <= 1'b0;
         trim_q     <= therm(CODE_RST);
      end else begin
         trim_q <= therm(code);
         if (!enable) begin
            cnt        <= '0;
            first      <= 1'b1;
            run        <= '0;
            locked     <= 1'b0;
            meas_valid <= 1'b0;
         end else begin
            cnt        <= rise ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1));
            meas_valid <= rise;
            if (rise) begin
               meas_count <= cnt;
            end
            // Bypass keeps the counter running as a frequency monitor but never touches the code.
            if (dco) begin
               first  <= 1'b1;
               run    <= '0;
               locked <= 1'b0;
            end else if (rise) begin
               if (first) begin
                  first <= 1'b0;
               end else if (too_fast) begin
                  if (code != CODE_TOP) code <= code + CODE_W'(1);
                  run    <= '0;
                  locked <= 1'b0;
               end else if (too_slow) begin
                  if (code != '0) code <= code - CODE_W'(1);
                  run    <= '0;
                  locked <= 1'b0;
               end else begin
                  run    <= run_nxt;
                  locked <= (run_inc >= LOCK_N);
               end
            end
         end
      end
   end

   assign trim = dco ? ext_trim : trim_q;

endmodule

// File: tb/tb_digital_fll_controller_p.sv
// Directed bench for digital_fll_controller_p: lock, slewing, tolerance edges, bypass, enable/reset and stuck osc.
module tb_digital_fll_controller_p;

   logic        clock;
   logic        reset;
   logic        enable;
   logic        osc;
   logic [4:0]  div;
   logic        dco;
   logic [25:0] ext_trim;
   logic [25:0] trim;
   logic [4:0]  code;
   logic [5:0]  meas_count;
   logic        meas_valid;
   logic        locked;

   int checks   = 0;
   int failures = 0;
   int osc_period = 0;
   int cur_p = 0;
   int ph = 0;
   int npulse;

   digital_fll_controller_p #(
      .DIV_W(5), .TRIM_W(26), .TOL(1), .LOCK_CNT(4), .INIT_CODE(13)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .osc        (osc),
      .div        (div),
      .dco        (dco),
      .ext_trim   (ext_trim),
      .trim       (trim),
      .code       (code),
      .meas_count (meas_count),
      .meas_valid (meas_valid),
      .locked     (locked)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference oscillator; a new period only takes effect at a period boundary.
   initial begin
      osc = 1'b0;
      forever begin
         @(negedge clock);
         if (ph == 0) cur_p = osc_period;
         if (cur_p == 0) begin
            osc = 1'b0;
         end else begin
            osc = (ph < cur_p / 2);
            ph  = (ph + 1 >= cur_p) ? 0 : ph + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_mv(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!meas_valid && n < 200);
      chk(tag, 32'(meas_valid), 32'd1);
   endtask

   task automatic skip_mv(input int k, input string tag);
      for (int i = 0; i < k; i++) wait_mv(tag);
   endtask

   task automatic count_mv(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(posedge clock);
         #1;
         if (meas_valid) c++;
      end
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      div      = 5'd8;
      dco      = 1'b0;
      ext_trim = '0;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_code", 32'(code), 32'd13);
      chk("rst_trim", 32'(trim), 32'h0001FFF);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_meas_count", 32'(meas_count), 32'd0);
      chk("rst_meas_valid", 32'(meas_valid), 32'd0);
      reset = 1'b0;

      // Lock at period 8: first measurement discarded, lock on the 4th in-band one.
      enable     = 1'b1;
      osc_period = 8;
      wait_mv("lock_p1");
      chk("lock_p1_code", 32'(code), 32'd13);
      skip_mv(2, "lock_p23");
      wait_mv("lock_p4");
      chk("lock_p4_count", 32'(meas_count), 32'd8);
      chk("lock_p4_locked", 32'(locked), 32'd0);
      wait_mv("lock_p5");
      chk("lock_p5_count", 32'(meas_count), 32'd8);
      chk("lock_p5_locked", 32'(locked), 32'd1);
      chk("lock_p5_code", 32'(code), 32'd13);

      // Tolerance edges: 9 and 7 stay in band, 10 steps up and drops lock.
      osc_period = 9;
      skip_mv(1, "tol9_skip");
      wait_mv("tol9");
      chk("tol9_count", 32'(meas_count), 32'd9);
      chk("tol9_locked", 32'(locked), 32'd1);
      chk("tol9_code", 32'(code), 32'd13);
      osc_period = 7;
      skip_mv(1, "tol7_skip");
      wait_mv("tol7");
      chk("tol7_count", 32'(meas_count), 32'd7);
      chk("tol7_locked", 32'(locked), 32'd1);
      chk("tol7_code", 32'(code), 32'd13);
      osc_period = 10;
      wait_mv("tol10_p1");
      chk("tol10_p1_locked", 32'(locked), 32'd1);
      wait_mv("tol10_p2");
      chk("tol10_p2_count", 32'(meas_count), 32'd10);
      chk("tol10_p2_code", 32'(code), 32'd14);
      chk("tol10_p2_locked", 32'(locked), 32'd0);
      wait_mv("tol10_p3");
      chk("tol10_p3_code", 32'(code), 32'd15);

      // Slew up to saturation.
      osc_period = 12;
      skip_mv(20, "up");
      chk("up_code", 32'(code), 32'd26);
      chk("up_trim", 32'(trim), 32'h3FFFFFF);
      chk("up_locked", 32'(locked), 32'd0);
      chk("up_count", 32'(meas_count), 32'd12);

      // Slew down to zero.
      osc_period = 6;
      skip_mv(30, "dn");
      chk("dn_code", 32'(code), 32'd0);
      chk("dn_trim", 32'(trim), 32'h0000000);
      chk("dn_locked", 32'(locked), 32'd0);
      chk("dn_count", 32'(meas_count), 32'd6);

      // Re-lock at code 0, then drop enable.
      osc_period = 8;
      skip_mv(6, "relock");
      chk("relock_locked", 32'(locked), 32'd1);
      chk("relock_code", 32'(code), 32'd0);
      enable = 1'b0;
      @(posedge clock);
      #1;
      chk("dis_locked", 32'(locked), 32'd0);
      chk("dis_code", 32'(code), 32'd0);
      count_mv(30, npulse);
      chk("dis_no_meas", 32'(npulse), 32'd0);

      // Bypass: trim follows ext_trim immediately, code frozen, monitor keeps measuring.
      enable     = 1'b1;
      dco        = 1'b1;
      ext_trim   = 26'h2AAAAAA;
      osc_period = 12;
      #1;
      chk("byp_trim", 32'(trim), 32'h2AAAAAA);
      skip_mv(4, "byp");
      chk("byp_count", 32'(meas_count), 32'd12);
      chk("byp_code", 32'(code), 32'd0);
      chk("byp_locked", 32'(locked), 32'd0);
      dco = 1'b0;
      wait_mv("rel_p1");
      chk("rel_p1_code", 32'(code), 32'd0);
      chk("rel_p1_trim", 32'(trim), 32'h0000000);
      wait_mv("rel_p2");
      chk("rel_p2_code", 32'(code), 32'd1);

      // Reset mid-period.
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("mrst_code", 32'(code), 32'd13);
      chk("mrst_trim", 32'(trim), 32'h0001FFF);
      chk("mrst_locked", 32'(locked), 32'd0);
      chk("mrst_meas_count", 32'(meas_count), 32'd0);
      chk("mrst_meas_valid", 32'(meas_valid), 32'd0);
      reset = 1'b0;

      // Stuck osc: no measurements, counter saturates at 63.
      osc_period = 0;
      repeat (30) @(posedge clock);
      count_mv(200, npulse);
      chk("stuck_no_meas", 32'(npulse), 32'd0);
      osc_period = 8;
      wait_mv("stuck_p1");
      chk("stuck_p1_count", 32'(meas_count), 32'd63);
      chk("stuck_p1_code", 32'(code), 32'd13);
      wait_mv("stuck_p2");
      chk("stuck_p2_count", 32'(meas_count), 32'd8);
      chk("stuck_p2_code", 32'(code), 32'd13);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
